mips_datapath_alu_muldiv_seq: RTL

- Owns the architectural HI/LO registers and sequences the multi-cycle integer divide that the single-cycle ALU does not perform.
- Sits beside the ALU in EX. It feeds reg_lo/reg_hi to the ALU for mfhi/mflo, and captures ALU res_lo/res_hi for mult/mthi/mtlo.
- Runs a radix-2 restoring divider for div/divu and asserts stall to the pipeline hazard unit while a result is pending.

---
 rtl/mips_datapath_alu_muldiv_seq_pkg.sv | 21 ++
 rtl/mips_datapath_alu_div_step.sv | 33 +++
 rtl/mips_datapath_alu_muldiv_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_datapath_alu_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO owner and divide sequencer.
// Holds the sequencer state encoding, the default operand width, the
// derived iteration-counter width and the most-negative operand value.
package mips_datapath_alu_muldiv_seq_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = $clog2(DIV_DATA_W);
  localparam logic [DIV_DATA_W-1:0] DIV_MOST_NEG = {1'b1, {(DIV_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

  // Iteration counter width for a given operand width.
  function automatic int unsigned div_cnt_w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/mips_datapath_alu_div_step.sv
// One combinational radix-2 restoring divide iteration.
// Ports:
//   rem_in, quo_in   current partial remainder / quotient shift register
//   divisor          divisor magnitude
//   rem_out, quo_out state after shifting {rem,quo} left and trial-subtracting
module mips_datapath_alu_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  // The partial remainder stays below the divisor between steps, so only the
  // shifted value needs the extra bit; the trial's MSB is its sign.
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  always_comb begin
    shifted = {rem_in, quo_in[DATA_W-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[DATA_W]) begin
      rem_out = trial[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end else begin
      rem_out = shifted[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_datapath_alu_muldiv_seq.sv
// HI/LO register owner and multi-cycle divide sequencer, beside the EX ALU.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   start, op_signed       begin div (op_signed=1) / divu on data1 / data2
//   wr_lo, wr_hi           load LO/HI from res_lo_in/res_hi_in (idle only)
//   read_req               EX instruction reads HI or LO
//   reg_lo, reg_hi         architectural LO/HI
//   busy, done, stall      divide in progress / result written / hold EX
module mips_datapath_alu_muldiv_seq
  import mips_datapath_alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op_signed,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [DATA_W-1:0] res_lo_in,
  input  logic [DATA_W-1:0] res_hi_in,
  input  logic              read_req,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi,
  output logic              busy,
  output logic              done,
  output logic              stall
);

  localparam int unsigned CNT_W = div_cnt_w(DATA_W);

  div_state_t        state, state_nxt;
  logic [DATA_W-1:0] rem, quo, divisor;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic [DATA_W-1:0] mag1, mag2;
  logic [CNT_W-1:0]  count;
  logic              qneg, rneg;
  logic              s1, s2;
  logic [DATA_W-1:0] lo, hi;

  assign s1   = op_signed & data1[DATA_W-1];
  assign s2   = op_signed & data2[DATA_W-1];
  assign mag1 = s1 ? (~data1 + DATA_W'(1)) : data1;
  assign mag2 = s2 ? (~data2 + DATA_W'(1)) : data2;

  mips_datapath_alu_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (divisor),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_DIV;
      ST_DIV:  if (count == CNT_W'(DATA_W-1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      count   <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      lo      <= '0;
      hi      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          // start wins over simultaneous HI/LO writes
          if (start) begin
            quo     <= mag1;
            divisor <= mag2;
            rem     <= '0;
            count   <= '0;
            qneg    <= s1 ^ s2;
            rneg    <= s1;
          end else begin
            if (wr_lo) lo <= res_lo_in;
            if (wr_hi) hi <= res_hi_in;
          end
        end
        ST_DIV: begin
          rem   <= step_rem;
          quo   <= step_quo;
          count <= count + CNT_W'(1);
        end
        ST_FIX: begin
          lo <= qneg ? (~quo + DATA_W'(1)) : quo;
          hi <= rneg ? (~rem + DATA_W'(1)) : rem;
        end
        default: ;
      endcase
    end
  end

  assign reg_lo = lo;
  assign reg_hi = hi;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_FIX);
  assign stall  = busy & (start | read_req | wr_lo | wr_hi);

endmodule
